alu_dec: RTL and testbench

- Decode/issue stage that produces the ALU control and operand interface: comparison select, op_0/op_1 selects, A/B operand data.
- Accepts a fetched RV32I instruction plus the register-file read data with a valid/ready handshake.
- Decodes ALU-class opcodes and presents a registered issue beat to the execute stage.
- A 2-entry skid buffer lets it absorb execute-stage back-pressure without a combinational ready path.

---
 rtl/alu_dec.sv | 217 +++++++++++++++++++++
 tb/tb_alu_dec.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_dec.sv
// rtl/alu_dec.sv - RV32I ALU decode/issue stage with 2-entry skid buffer
//
// Decodes ALU-class RV32I instructions (OP, OP-IMM, LUI, AUIPC, BRANCH) into
// ALU control selects and operands, and registers them into a 1-cycle issue
// stage. A skid entry absorbs execute-stage back-pressure so that inst_ready_o
// is a pure register output.
//
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   flush_i              synchronous flush, drops both entries and the input beat
//   inst_valid_i/ready_o input handshake; inst_data_i, inst_pc_i, rs1/rs2_data_i
//   dec_valid_o/ready_i  issue handshake
//   alu_*_o              comparison select, op_0/op_1 selects, A/B operands
//   rd_addr_o, rd_wr_en_o, is_branch_o, illegal_o  decoded side information
module alu_dec #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            inst_valid_i,
  output logic            inst_ready_o,
  input  logic [31:0]     inst_data_i,
  input  logic [XLEN-1:0] inst_pc_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic            dec_valid_o,
  input  logic            dec_ready_i,
  output logic [2:0]      alu_comp_sel_o,
  output logic            alu_op_0_sel_o,
  output logic [2:0]      alu_op_1_sel_o,
  output logic [XLEN-1:0] alu_a_data_o,
  output logic [XLEN-1:0] alu_b_data_o,
  output logic [4:0]      rd_addr_o,
  output logic            rd_wr_en_o,
  output logic            is_branch_o,
  output logic            illegal_o
);

  localparam logic [2:0] ALU_COMP_NONE = 3'd0;
  localparam logic [2:0] ALU_COMP_BEQ  = 3'd1;
  localparam logic [2:0] ALU_COMP_BNE  = 3'd2;
  localparam logic [2:0] ALU_COMP_BLT  = 3'd3;
  localparam logic [2:0] ALU_COMP_BGE  = 3'd4;
  localparam logic [2:0] ALU_COMP_BLTU = 3'd5;
  localparam logic [2:0] ALU_COMP_BGEU = 3'd6;

  // ALU_OP_1_* codes equal the RV32I funct3 of the operation:
  // ADD=0 SLL=1 SLT=2 SLTU=3 XOR=4 SRL=5 OR=6 AND=7
  localparam logic [2:0] ALU_OP_1_ADD = 3'd0;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  // Packed issue beat: comp, op_0, op_1, A, B, rd, wr_en, is_branch, illegal
  localparam int W = 3 + 1 + 3 + XLEN + XLEN + 5 + 1 + 1 + 1;

  logic [6:0]        w_opcode;
  logic [2:0]        w_funct3;
  logic [6:0]        w_funct7;
  logic signed [11:0] w_imm_i;
  logic signed [31:0] w_imm_u;

  logic [2:0]      w_comp;
  logic            w_op0;
  logic [2:0]      w_op1;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic [4:0]      w_rd;
  logic            w_wr;
  logic            w_br;
  logic            w_legal;
  logic [W-1:0]    w_dec;

  logic            r_main_valid;
  logic [W-1:0]    r_main;
  logic            r_skid_valid;
  logic [W-1:0]    r_skid;

  logic            w_in_fire;
  logic            w_main_free;

  assign w_opcode = inst_data_i[6:0];
  assign w_funct3 = inst_data_i[14:12];
  assign w_funct7 = inst_data_i[31:25];
  assign w_imm_i  = inst_data_i[31:20];
  assign w_imm_u  = {inst_data_i[31:12], 12'b0};

  always_comb begin
    w_comp  = ALU_COMP_NONE;
    w_op0   = 1'b0;
    w_op1   = ALU_OP_1_ADD;
    w_a     = '0;
    w_b     = '0;
    w_rd    = '0;
    w_wr    = 1'b0;
    w_br    = 1'b0;
    w_legal = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        w_op1 = w_funct3;
        w_a   = rs1_data_i;
        w_b   = rs2_data_i;
        w_rd  = inst_data_i[11:7];
        w_wr  = 1'b1;
        // Only ADD/SUB and SRL/SRA have an alternate funct7 encoding.
        if (w_funct3 == 3'b000 || w_funct3 == 3'b101) begin
          w_op0   = inst_data_i[30];
          w_legal = (w_funct7 == F7_ZERO) || (w_funct7 == F7_ALT);
        end else begin
          w_legal = (w_funct7 == F7_ZERO);
        end
      end
      OPC_OP_IMM: begin
        w_op1 = w_funct3;
        w_a   = rs1_data_i;
        w_b   = XLEN'(w_imm_i);
        w_rd  = inst_data_i[11:7];
        w_wr  = 1'b1;
        // inst[30] is an immediate bit except for shifts, so ADDI never subtracts.
        case (w_funct3)
          3'b001:  w_legal = (w_funct7 == F7_ZERO);
          3'b101: begin
            w_op0   = inst_data_i[30];
            w_legal = (w_funct7 == F7_ZERO) || (w_funct7 == F7_ALT);
          end
          default: w_legal = 1'b1;
        endcase
      end
      OPC_LUI: begin
        w_b     = XLEN'(w_imm_u);
        w_rd    = inst_data_i[11:7];
        w_wr    = 1'b1;
        w_legal = 1'b1;
      end
      OPC_AUIPC: begin
        w_a     = inst_pc_i;
        w_b     = XLEN'(w_imm_u);
        w_rd    = inst_data_i[11:7];
        w_wr    = 1'b1;
        w_legal = 1'b1;
      end
      OPC_BRANCH: begin
        w_a     = rs1_data_i;
        w_b     = rs2_data_i;
        w_br    = 1'b1;
        w_legal = 1'b1;
        case (w_funct3)
          3'b000:  w_comp = ALU_COMP_BEQ;
          3'b001:  w_comp = ALU_COMP_BNE;
          3'b100:  w_comp = ALU_COMP_BLT;
          3'b101:  w_comp = ALU_COMP_BGE;
          3'b110:  w_comp = ALU_COMP_BLTU;
          3'b111:  w_comp = ALU_COMP_BGEU;
          default: w_legal = 1'b0;
        endcase
      end
      default: ;
    endcase
    if (!w_legal) begin
      w_comp = ALU_COMP_NONE;
      w_op0  = 1'b0;
      w_op1  = ALU_OP_1_ADD;
      w_a    = '0;
      w_b    = '0;
      w_rd   = '0;
      w_wr   = 1'b0;
      w_br   = 1'b0;
    end
  end

  assign w_dec = {w_comp, w_op0, w_op1, w_a, w_b, w_rd,
                  w_wr & (w_rd != 5'd0), w_br, ~w_legal};

  // Ready depends only on the skid register, so no combinational path from
  // dec_ready_i to inst_ready_o exists.
  assign inst_ready_o = ~r_skid_valid;
  assign w_in_fire    = inst_valid_i & ~r_skid_valid;
  assign w_main_free  = ~r_main_valid | dec_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_main_valid <= 1'b0;
      r_main       <= '0;
      r_skid_valid <= 1'b0;
      r_skid       <= '0;
    end else if (flush_i) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_main_free) begin
      // A full skid implies inst_ready_o was 0, so no input beat competes here.
      if (r_skid_valid) begin
        r_main       <= r_skid;
        r_main_valid <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        r_main_valid <= w_in_fire;
        if (w_in_fire) begin
          r_main <= w_dec;
        end
      end
    end else if (w_in_fire) begin
      r_skid       <= w_dec;
      r_skid_valid <= 1'b1;
    end
  end

  assign dec_valid_o = r_main_valid;
  assign {alu_comp_sel_o, alu_op_0_sel_o, alu_op_1_sel_o, alu_a_data_o,
          alu_b_data_o, rd_addr_o, rd_wr_en_o, is_branch_o, illegal_o} = r_main;

endmodule

// File: tb/tb_alu_dec.sv
// tb/tb_alu_dec.sv - self-checking bench for alu_dec
module tb_alu_dec;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        inst_valid_i;
  logic        inst_ready_o;
  logic [31:0] inst_data_i;
  logic [31:0] inst_pc_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        dec_valid_o;
  logic        dec_ready_i;
  logic [2:0]  alu_comp_sel_o;
  logic        alu_op_0_sel_o;
  logic [2:0]  alu_op_1_sel_o;
  logic [31:0] alu_a_data_o;
  logic [31:0] alu_b_data_o;
  logic [4:0]  rd_addr_o;
  logic        rd_wr_en_o;
  logic        is_branch_o;
  logic        illegal_o;

  alu_dec #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o),
    .inst_data_i(inst_data_i), .inst_pc_i(inst_pc_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
    .alu_comp_sel_o(alu_comp_sel_o), .alu_op_0_sel_o(alu_op_0_sel_o),
    .alu_op_1_sel_o(alu_op_1_sel_o), .alu_a_data_o(alu_a_data_o),
    .alu_b_data_o(alu_b_data_o), .rd_addr_o(rd_addr_o),
    .rd_wr_en_o(rd_wr_en_o), .is_branch_o(is_branch_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [2:0]  comp;
    logic        op0;
    logic [2:0]  op1;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        wr;
    logic        br;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decode: comparison codes BEQ=1 BNE=2 BLT=3 BGE=4 BLTU=5 BGEU=6,
  // op_1 codes are the RV32I funct3 of the operation.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs1,
                                 input logic [31:0] rs2, input logic [31:0] pc);
    exp_t       e;
    logic [6:0] f7;
    logic [2:0] f3;
    logic       ok;
    int         comp_of[8];
    e = '0;
    ok = 1'b0;
    f7 = ins[31:25];
    f3 = ins[14:12];
    comp_of = '{1, 2, 0, 0, 3, 4, 5, 6};
    case (ins[6:0])
      7'h33: begin
        ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        e.op1 = f3; e.op0 = (f7 == 7'h20); e.a = rs1; e.b = rs2; e.rd = ins[11:7];
      end
      7'h13: begin
        ok = (f3 == 3'd1) ? (f7 == 7'h00) :
             (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
        e.op1 = f3; e.op0 = (f3 == 3'd5) && (f7 == 7'h20);
        e.a = rs1; e.b = 32'($signed(ins[31:20])); e.rd = ins[11:7];
      end
      7'h37: begin
        ok = 1'b1; e.b = {ins[31:12], 12'h000}; e.rd = ins[11:7];
      end
      7'h17: begin
        ok = 1'b1; e.a = pc; e.b = {ins[31:12], 12'h000}; e.rd = ins[11:7];
      end
      7'h63: begin
        ok = (f3 != 3'd2) && (f3 != 3'd3);
        e.a = rs1; e.b = rs2; e.br = 1'b1; e.comp = 3'(comp_of[f3]);
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e = '0;
      e.ill = 1'b1;
    end
    e.wr = !e.ill && !e.br && (e.rd != 5'd0);
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    int          k;
    logic [31:0] r;
    logic [6:0]  f7;
    k = $urandom_range(0, 5);
    r = $urandom;
    case ($urandom_range(0, 2))
      0:       f7 = 7'h00;
      1:       f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    case (k)
      0:       rand_inst = {f7, r[24:7], 7'h33};
      1:       rand_inst = {f7, r[24:7], 7'h13};
      2:       rand_inst = {r[31:7], 7'h37};
      3:       rand_inst = {r[31:7], 7'h17};
      4:       rand_inst = {r[31:7], 7'h63};
      default: rand_inst = r;
    endcase
  endfunction

  task automatic check_outputs();
    chk("dec_valid", dec_valid_o, q.size() > 0);
    chk("inst_ready", inst_ready_o, q.size() < 2);
    if (q.size() > 0) begin
      chk("comp", alu_comp_sel_o, q[0].comp);
      chk("op0", alu_op_0_sel_o, q[0].op0);
      chk("op1", alu_op_1_sel_o, q[0].op1);
      chk("a", alu_a_data_o, q[0].a);
      chk("b", alu_b_data_o, q[0].b);
      chk("rd", rd_addr_o, q[0].rd);
      chk("wr_en", rd_wr_en_o, q[0].wr);
      chk("is_branch", is_branch_o, q[0].br);
      chk("illegal", illegal_o, q[0].ill);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_valid"}, dec_valid_o, 0);
    chk({tag, "_ready"}, inst_ready_o, 1);
    chk({tag, "_data"}, {alu_comp_sel_o, alu_op_0_sel_o, alu_op_1_sel_o, rd_addr_o,
                         rd_wr_en_o, is_branch_o, illegal_o}, 0);
    chk({tag, "_a"}, alu_a_data_o, 0);
    chk({tag, "_b"}, alu_b_data_o, 0);
  endtask

  // One clock: drive inputs, advance the scoreboard on the edge, check #1 later.
  task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] pc,
                     input logic rdy, input logic fl);
    logic acc;
    logic con;
    exp_t e;
    inst_valid_i = v; inst_data_i = ins; rs1_data_i = a; rs2_data_i = b;
    inst_pc_i = pc; dec_ready_i = rdy; flush_i = fl;
    acc = v && (q.size() < 2);
    con = rdy && (q.size() > 0);
    e = model(ins, a, b, pc);
    @(posedge clk_i);
    if (fl) begin
      q.delete();
    end else begin
      if (con) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    #1;
    check_outputs();
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; inst_valid_i = 1'b0; inst_data_i = '0;
    inst_pc_i = '0; rs1_data_i = '0; rs2_data_i = '0; dec_ready_i = 1'b0;
    #1;
    check_reset("rst_init");
    repeat (2) @(posedge clk_i);
    #1;
    check_reset("rst_hold");
    @(negedge clk_i);
    rst_i = 1'b0;

    // R-type ADD / SUB
    cyc(1, 32'h002081B3, 32'd5, 32'd7, 32'h100, 1, 0);
    chk("add_op1", alu_op_1_sel_o, 0);
    chk("add_op0", alu_op_0_sel_o, 0);
    chk("add_a", alu_a_data_o, 5);
    chk("add_b", alu_b_data_o, 7);
    chk("add_rd", rd_addr_o, 3);
    chk("add_wr", rd_wr_en_o, 1);
    cyc(1, 32'h402081B3, 32'd5, 32'd7, 32'h104, 1, 0);
    chk("sub_op0", alu_op_0_sel_o, 1);

    // Immediates
    cyc(1, 32'hFFF00093, 32'd0, 32'd9, 32'h108, 1, 0);
    chk("addi_b", alu_b_data_o, 32'hFFFFFFFF);
    chk("addi_op0", alu_op_0_sel_o, 0);
    cyc(1, 32'h4030D093, 32'h80000000, 32'd0, 32'h10C, 1, 0);
    chk("srai_op1", alu_op_1_sel_o, 5);
    chk("srai_op0", alu_op_0_sel_o, 1);
    chk("srai_sh", alu_b_data_o[4:0], 3);
    cyc(1, 32'h12345037, 32'd11, 32'd12, 32'h110, 1, 0);
    chk("lui_a", alu_a_data_o, 0);
    chk("lui_b", alu_b_data_o, 32'h12345000);

    // Branch, illegal, rd=x0
    cyc(1, 32'h0020C463, 32'd1, 32'd2, 32'h114, 1, 0);
    chk("blt_comp", alu_comp_sel_o, 3);
    chk("blt_br", is_branch_o, 1);
    chk("blt_wr", rd_wr_en_o, 0);
    cyc(1, 32'hFFFFFFFF, 32'd1, 32'd2, 32'h118, 1, 0);
    chk("ill_flag", illegal_o, 1);
    chk("ill_wr", rd_wr_en_o, 0);
    cyc(1, 32'h00208033, 32'd1, 32'd2, 32'h11C, 1, 0);
    chk("x0_wr", rd_wr_en_o, 0);
    cyc(0, 32'h0, 32'd0, 32'd0, 32'h0, 1, 0);

    // Back-pressure: ADDI x1/x2/x3 with dec_ready_i low for 4 cycles
    cyc(1, 32'h00100093, 32'd10, 32'd0, 32'h200, 0, 0);
    cyc(1, 32'h00200113, 32'd20, 32'd0, 32'h204, 0, 0);
    chk("bp_ready_low", inst_ready_o, 0);
    cyc(1, 32'h00300193, 32'd30, 32'd0, 32'h208, 0, 0);
    cyc(1, 32'h00300193, 32'd30, 32'd0, 32'h208, 0, 0);
    chk("bp_hold_rd", rd_addr_o, 1);
    cyc(1, 32'h00300193, 32'd30, 32'd0, 32'h208, 1, 0);
    chk("bp_out2_rd", rd_addr_o, 2);
    cyc(1, 32'h00300193, 32'd30, 32'd0, 32'h208, 1, 0);
    chk("bp_out3_rd", rd_addr_o, 3);
    cyc(0, 32'h0, 32'd0, 32'd0, 32'h0, 1, 0);
    chk("bp_drained", dec_valid_o, 0);

    // Flush with both entries full and a beat on the input
    cyc(1, 32'h00500293, 32'd1, 32'd0, 32'h300, 0, 0);
    cyc(1, 32'h00600313, 32'd2, 32'd0, 32'h304, 0, 0);
    cyc(1, 32'h00700393, 32'd3, 32'd0, 32'h308, 0, 1);
    chk("flush_valid", dec_valid_o, 0);
    chk("flush_ready", inst_ready_o, 1);
    cyc(0, 32'h0, 32'd0, 32'd0, 32'h0, 1, 0);

    // Asynchronous reset mid-stream with a beat held on the outputs
    cyc(1, 32'h002081B3, 32'd5, 32'd7, 32'h400, 0, 0);
    #2;
    rst_i = 1'b1;
    #1;
    check_reset("rst_async");
    @(posedge clk_i);
    #1;
    check_reset("rst_edge");
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check_reset("rst_release");
    q.delete();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 3) != 0, rand_inst(), $urandom, $urandom, $urandom,
          $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
